// File: rtl/lut_burst_arb.sv
// lut_burst_arb: round-robin arbiter + 3-beat burst sequencer in front of a
// static 4x2x3 lookup table. Each winning requester gets the row
// tbl[a][b][2..0] streamed out as three valid/ready beats, highest index first.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   tbl                 table contents, static after reset
//   req/sel_a/sel_b     per-requester request level and row indices
//   gnt                 one-hot grant, held from arbitration to last beat
//   rd_valid/rd_ready   beat handshake
//   rd_data/rd_idx      beat payload and its third index (2,1,0)
//   rd_last             final beat marker
//   busy                transaction in progress
//
// Build option: define LUT_BURST_ARB_FIXED_PRIO_EN to pin the search pointer
// at 0 (lowest-index requester always wins, starvation allowed).
module lut_burst_arb #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [0:3][0:1][2:0][W-1:0]          tbl,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ-1:0][1:0]                 sel_a,
  input  logic [NREQ-1:0]                      sel_b,
  output logic [NREQ-1:0]                      gnt,
  output logic                                 rd_valid,
  input  logic                                 rd_ready,
  output logic [W-1:0]                         rd_data,
  output logic [1:0]                           rd_idx,
  output logic                                 rd_last,
  output logic                                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   win_c;
  logic            found;
  logic [1:0]      a;
  logic            b;
  logic [1:0]      nidx;
  logic            xfer;
  logic            done;
  int              j;

  assign xfer = rd_valid && rd_ready;
  assign done = (state == BURST) && xfer && (rd_idx == 2'd0);
  assign nidx = rd_idx - 2'd1;

  // Winner search: first asserted req scanning upward from ptr, wrapping.
  always_comb begin
    win_c = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win_c = PW'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   state_nxt = BURST;
      BURST:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_idx   <= 2'd0;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      win      <= '0;
      a        <= 2'd0;
      b        <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (found) begin
            gnt <= {{(NREQ-1){1'b0}}, 1'b1} << win_c;
            win <= win_c;
            // Indices are captured once here; later sel changes are ignored.
            a   <= sel_a[win_c];
            b   <= sel_b[win_c];
          end
        end
        GRANT: begin
          rd_valid <= 1'b1;
          rd_data  <= tbl[a][b][2];
          rd_idx   <= 2'd2;
          rd_last  <= 1'b0;
        end
        BURST: begin
          if (xfer) begin
            if (rd_idx != 2'd0) begin
              rd_idx  <= nidx;
              rd_data <= tbl[a][b][nidx];
              rd_last <= (nidx == 2'd0);
            end else begin
              rd_valid <= 1'b0;
              gnt      <= '0;
`ifdef LUT_BURST_ARB_FIXED_PRIO_EN
              ptr      <= '0;
`else
              ptr      <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
